// File: rtl/acam_clk_pkg.sv
// Shared clocking definitions for the mic-array front end.
// FSM states, default rates and a counter-width helper.
package acam_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } clk_state_e;

  localparam int SCK_DIV_DEF     = 13;
  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int BITS_PER_CH_DEF = 32;

  // Width of a counter holding 0..n-1, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_sck_div.sv
// I2S bit-clock divider, word select and edge strobes.
// Ports: i_clk, i_rst, i_en (run qualifier, clears when 0),
//   o_sck, o_ws, o_sck_rise, o_sck_fall, o_frame_start.
module i2s_sck_div
  import acam_clk_pkg::*;
#(
  parameter int SCK_DIV     = SCK_DIV_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sck,
  output logic o_ws,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_frame_start
);

  localparam int DW = cnt_w(SCK_DIV);
  localparam int BW = cnt_w(2 * BITS_PER_CH);

  localparam logic [DW-1:0] DIV_MAX =
    DW'(SCK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX =
    BW'(2 * BITS_PER_CH - 1);
  localparam logic [BW-1:0] BIT_HALF =
    BW'(BITS_PER_CH);

  logic [DW-1:0] r_div_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_sck;
  logic          r_ws;
  logic          r_rise;
  logic          r_fall;
  logic          r_fs;

  logic          w_wrap;
  logic [BW-1:0] w_bit_nxt;

  assign w_wrap = (r_div_cnt == DIV_MAX);

  // Explicit wrap so a non power-of-two frame
  // length still counts 0..2*BITS_PER_CH-1.
  assign w_bit_nxt = (r_bit_cnt == BIT_MAX)
                   ? '0
                   : r_bit_cnt + BW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_fs   <= 1'b0;
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_sck     <= !r_sck;
        // Strobes are registered with sck so they
        // line up with the cycle showing the new level.
        if (r_sck) begin
          r_fall    <= 1'b1;
          r_bit_cnt <= w_bit_nxt;
          r_ws      <= (w_bit_nxt >= BIT_HALF);
          r_fs      <= (w_bit_nxt == '0);
        end else begin
          r_rise <= 1'b1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
    end
  end

  assign o_sck         = r_sck;
  assign o_ws          = r_ws;
  assign o_sck_rise    = r_rise;
  assign o_sck_fall    = r_fall;
  assign o_frame_start = r_fs;

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S sck/ws generator with PLL-lock qualified reset.
// Ports: clkin, reset, pll_lock in; rst_out, sck, ws,
//   sck_rise, sck_fall, frame_start out.
module i2s_clk_gen
  import acam_clk_pkg::*;
#(
  parameter int SCK_DIV     = SCK_DIV_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
  input  logic clkin,
  input  logic reset,
  input  logic pll_lock,
  output logic rst_out,
  output logic sck,
  output logic ws,
  output logic sck_rise,
  output logic sck_fall,
  output logic frame_start
);

  localparam int LW = cnt_w(LOCK_CYCLES);

  localparam logic [LW-1:0] LC_MAX =
    LW'(LOCK_CYCLES - 1);

  clk_state_e    r_state;
  clk_state_e    w_state_nxt;
  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_lock_cnt_nxt;
  logic          r_rst_out;
  logic          w_run_en;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      WAIT_LOCK: begin
        if (pll_lock) begin
          w_state_nxt    = STABLE;
          w_lock_cnt_nxt = '0;
        end
      end
      STABLE: begin
        if (!pll_lock) begin
          w_state_nxt    = WAIT_LOCK;
          w_lock_cnt_nxt = '0;
        end else if (r_lock_cnt == LC_MAX) begin
          w_state_nxt    = RUN;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + LW'(1);
        end
      end
      RUN: begin
        if (!pll_lock) begin
          w_state_nxt    = WAIT_LOCK;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = WAIT_LOCK;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state    <= WAIT_LOCK;
      r_lock_cnt <= '0;
      r_rst_out  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rst_out  <= (w_state_nxt != RUN);
    end
  end

  // Divider runs only on edges that stay in RUN, so the
  // first sck rise lands SCK_DIV edges after RUN entry
  // and lock loss clears sck on the sampling edge.
  assign w_run_en = (r_state == RUN) && pll_lock;

  i2s_sck_div #(
    .SCK_DIV    (SCK_DIV),
    .BITS_PER_CH(BITS_PER_CH)
  ) u_div (
    .i_clk        (clkin),
    .i_rst        (reset),
    .i_en         (w_run_en),
    .o_sck        (sck),
    .o_ws         (ws),
    .o_sck_rise   (sck_rise),
    .o_sck_fall   (sck_fall),
    .o_frame_start(frame_start)
  );

  assign rst_out = r_rst_out;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Scoreboard bench for i2s_clk_gen at three parameter sets.
// Expected outputs come from a lock-run-length timing model.
module tb_i2s_clk_gen;

  localparam int DA = 13, LA = 1024, BA = 32;
  localparam int DB = 2,  LB = 8,    BB = 3;
  localparam int DC = 3,  LC = 1,    BC = 2;

  logic clk = 1'b0;
  logic reset;
  logic pll_lock;

  logic a_rst, a_sck, a_ws, a_ri, a_fa, a_fs;
  logic b_rst, b_sck, b_ws, b_ri, b_fa, b_fs;
  logic c_rst, c_sck, c_ws, c_ri, c_fa, c_fs;

  always #5 clk = ~clk;

  i2s_clk_gen #(
    .SCK_DIV(DA), .LOCK_CYCLES(LA), .BITS_PER_CH(BA)
  ) dut_a (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock),
    .rst_out(a_rst), .sck(a_sck), .ws(a_ws),
    .sck_rise(a_ri), .sck_fall(a_fa),
    .frame_start(a_fs)
  );

  i2s_clk_gen #(
    .SCK_DIV(DB), .LOCK_CYCLES(LB), .BITS_PER_CH(BB)
  ) dut_b (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock),
    .rst_out(b_rst), .sck(b_sck), .ws(b_ws),
    .sck_rise(b_ri), .sck_fall(b_fa),
    .frame_start(b_fs)
  );

  i2s_clk_gen #(
    .SCK_DIV(DC), .LOCK_CYCLES(LC), .BITS_PER_CH(BC)
  ) dut_c (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock),
    .rst_out(c_rst), .sck(c_sck), .ws(c_ws),
    .sck_rise(c_ri), .sck_fall(c_fa),
    .frame_start(c_fs)
  );

  typedef struct {
    int         cyc;
    logic [5:0] ea;
    logic [5:0] eb;
    logic [5:0] ec;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   run_len  = 0;

  // n = consecutive non-reset edges sampling lock=1.
  // Release happens at n = L+1; t counts edges since.
  function automatic logic [5:0] model(
    input int n, input int L,
    input int D, input int B
  );
    int t, k, f, b;
    logic edg, s, ri, fa, w, fs;
    if (n < L + 1) return 6'b100000;
    t   = n - (L + 1);
    k   = t / D;
    edg = (t > 0) && (t % D == 0);
    s   = (k % 2) == 1;
    ri  = edg && s;
    fa  = edg && !s;
    f   = k / 2;
    b   = f % (2 * B);
    w   = (b >= B);
    fs  = fa && (b == 0);
    return {1'b0, s, w, ri, fa, fs};
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (reset || !pll_lock) run_len = 0;
    else run_len++;
    e.cyc = cyc;
    e.ea  = model(run_len, LA, DA, BA);
    e.eb  = model(run_len, LB, DB, BB);
    e.ec  = model(run_len, LC, DC, BC);
    q.push_back(e);
  end

  task automatic chk(
    input string nm, input int c,
    input logic [5:0] act, input logic [5:0] exp
  );
    n_checks++;
    if (act === exp) n_pass++;
    else $display(
      "FAIL %s cyc=%0d got=%b want=%b (rst,sck,ws,ri,fa,fs)",
      nm, c, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dut_a", e.cyc,
          {a_rst, a_sck, a_ws, a_ri, a_fa, a_fs}, e.ea);
      chk("dut_b", e.cyc,
          {b_rst, b_sck, b_ws, b_ri, b_fa, b_fs}, e.eb);
      chk("dut_c", e.cyc,
          {c_rst, c_sck, c_ws, c_ri, c_fa, c_fs}, e.ec);
    end
  end

  task automatic drive(
    input logic r, input logic l, input int n
  );
    reset    = r;
    pll_lock = l;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, LA + 1 + 2 * 1664 + 50);
    drive(1'b0, 1'b1, 5);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 20);
    repeat (40) begin
      drive(1'b0, 1'b1, $urandom_range(1, 30));
      drive(1'b0, 1'b0, $urandom_range(1, 2));
    end
    drive(1'b0, 1'b1,
          LA + 1 + 40 * 26 + $urandom_range(0, 25));
    drive(1'b0, 1'b0, $urandom_range(1, 3));
    drive(1'b0, 1'b1, LA + 1 + 1664 + 100);
    drive(1'b1, 1'b1, $urandom_range(1, 3));
    drive(1'b0, 1'b1, LA + 1 + 600);
    repeat (150) begin
      drive($urandom_range(0, 9) == 0,
            $urandom_range(0, 5) != 0,
            $urandom_range(1, 12));
    end
    drive(1'b0, 1'b1, 60);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d want=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
